// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
package rf_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Upper address bits are ignored: the index is the address modulo the depth.
    function automatic int unsigned index_of(input logic [63:0] addr, input int unsigned depth);
        return 32'(addr & 64'(depth - 1));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits with reserve/clear priority, busy count and forwarded busy lookups.
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] ridx1_i,
    input  logic [IDX_W-1:0] ridx2_i,
    input  logic             write_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic             reserve_i,
    input  logic [IDX_W-1:0] rsv_idx_i,
    output logic             busy1_o,
    output logic             busy2_o,
    output logic [IDX_W:0]   busy_count_o
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             inc, dec;

    always_comb begin
        busy_d = busy_q;
        if (write_i) busy_d[widx_i] = 1'b0;
        // A reservation on the same edge as a write marks the new producer.
        if (reserve_i) busy_d[rsv_idx_i] = 1'b1;

        inc = reserve_i && !busy_q[rsv_idx_i];
        dec = write_i && busy_q[widx_i] && !(reserve_i && (rsv_idx_i == widx_i));
        count_d = count_q;
        unique case ({inc, dec})
            2'b10:   count_d = count_q + (IDX_W + 1)'(1);
            2'b01:   count_d = count_q - (IDX_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy1_o      = busy_q[ridx1_i] & ~(write_i & (widx_i == ridx1_i));
    assign busy2_o      = busy_q[ridx2_i] & ~(write_i & (widx_i == ridx2_i));
    assign busy_count_o = count_q;

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file: two combinational read ports with write bypass,
// one clocked write port, optional hardwired-zero r0 and a busy scoreboard.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned DEPTH   = DefDepth,
    parameter int unsigned ADDR_W  = 6,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_W-1:0]        raddr1_i,
    input  logic [ADDR_W-1:0]        raddr2_i,
    output logic [WIDTH-1:0]         rdata1_o,
    output logic [WIDTH-1:0]         rdata2_o,
    output logic                     busy1_o,
    output logic                     busy2_o,
    input  logic                     write_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     reserve_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic [clog2(DEPTH):0]    busy_count_o
);

    localparam int unsigned IdxW = clog2(DEPTH);

    logic [IdxW-1:0]  ridx1, ridx2, widx, rsv_idx;
    logic             we, rsv;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign ridx1   = IdxW'(index_of(64'(raddr1_i), DEPTH));
    assign ridx2   = IdxW'(index_of(64'(raddr2_i), DEPTH));
    assign widx    = IdxW'(index_of(64'(waddr_i), DEPTH));
    assign rsv_idx = IdxW'(index_of(64'(rsv_addr_i), DEPTH));

    // Suppressing writes/reservations to r0 keeps its storage, bypass and busy bit at zero.
    assign we  = write_i & ~(ZERO_R0 && (widx == '0));
    assign rsv = reserve_i & ~(ZERO_R0 && (rsv_idx == '0));

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mem_q[g] <= '0;
            end else if (we && (widx == IdxW'(g))) begin
                mem_q[g] <= wdata_i;
            end
        end
    end

    assign rdata1_o = (we && !rst_i && (widx == ridx1)) ? wdata_i : mem_q[ridx1];
    assign rdata2_o = (we && !rst_i && (widx == ridx2)) ? wdata_i : mem_q[ridx2];

    reg_scoreboard #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ridx1_i      (ridx1),
        .ridx2_i      (ridx2),
        .write_i      (we),
        .widx_i       (widx),
        .reserve_i    (rsv),
        .rsv_idx_i    (rsv_idx),
        .busy1_o      (busy1_o),
        .busy2_o      (busy2_o),
        .busy_count_o (busy_count_o)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two instances (ZERO_R0=0 and 1) checked against an array model.
module tb_register_file_sb;

    logic        clk;
    logic        rst;
    logic [5:0]  raddr1, raddr2, waddr, rsv_addr;
    logic        write, reserve;
    logic [31:0] wdata;
    logic [31:0] rdata1 [2];
    logic [31:0] rdata2 [2];
    logic        busy1 [2];
    logic        busy2 [2];
    logic [3:0]  bcnt [2];

    int checks = 0;
    int errors = 0;

    // Model state: index 0 = plain instance, index 1 = hardwired-zero instance.
    logic [31:0] m_reg  [2][8];
    logic        m_busy [2][8];

    register_file_sb #(.WIDTH(32), .DEPTH(8), .ADDR_W(6), .ZERO_R0(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .raddr1_i(raddr1), .raddr2_i(raddr2),
        .rdata1_o(rdata1[0]), .rdata2_o(rdata2[0]), .busy1_o(busy1[0]), .busy2_o(busy2[0]),
        .write_i(write), .waddr_i(waddr), .wdata_i(wdata), .reserve_i(reserve),
        .rsv_addr_i(rsv_addr), .busy_count_o(bcnt[0])
    );

    register_file_sb #(.WIDTH(32), .DEPTH(8), .ADDR_W(6), .ZERO_R0(1'b1)) dut_z (
        .clk_i(clk), .rst_i(rst), .raddr1_i(raddr1), .raddr2_i(raddr2),
        .rdata1_o(rdata1[1]), .rdata2_o(rdata2[1]), .busy1_o(busy1[1]), .busy2_o(busy2[1]),
        .write_i(write), .waddr_i(waddr), .wdata_i(wdata), .reserve_i(reserve),
        .rsv_addr_i(rsv_addr), .busy_count_o(bcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ignored(input int z, input int idx);
        return (z == 1) && (idx == 0);
    endfunction

    function automatic logic [31:0] exp_rdata(input int z, input logic [5:0] a);
        int idx;
        idx = a % 8;
        if (ignored(z, idx)) return 32'h0;
        if (write && !rst && (waddr % 8) == idx) return wdata;
        return m_reg[z][idx];
    endfunction

    function automatic logic exp_busy(input int z, input logic [5:0] a);
        int idx;
        idx = a % 8;
        if (ignored(z, idx)) return 1'b0;
        if (write && !rst && (waddr % 8) == idx) return 1'b0;
        return m_busy[z][idx];
    endfunction

    function automatic logic [31:0] exp_count(input int z);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_busy[z][i]);
        return 32'(n);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int z = 0; z < 2; z++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    m_reg[z][i]  = '0;
                    m_busy[z][i] = 1'b0;
                end
            end else begin
                if (write && !ignored(z, waddr % 8)) begin
                    m_reg[z][waddr % 8]  = wdata;
                    m_busy[z][waddr % 8] = 1'b0;
                end
                if (reserve && !ignored(z, rsv_addr % 8)) m_busy[z][rsv_addr % 8] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int z = 0; z < 2; z++) begin
            check($sformatf("rdata1[z%0d]", z), rdata1[z], exp_rdata(z, raddr1));
            check($sformatf("rdata2[z%0d]", z), rdata2[z], exp_rdata(z, raddr2));
            check($sformatf("busy1[z%0d]", z), 32'(busy1[z]), 32'(exp_busy(z, raddr1)));
            check($sformatf("busy2[z%0d]", z), 32'(busy2[z]), 32'(exp_busy(z, raddr2)));
            check($sformatf("busy_count[z%0d]", z), 32'(bcnt[z]), exp_count(z));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = 1'b0; reserve = 1'b0;
    endtask

    initial begin
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 8; i++) begin
                m_reg[z][i] = '0; m_busy[z][i] = 1'b0;
            end
        rst = 1'b1; write = 1'b0; reserve = 1'b0;
        raddr1 = 6'd0; raddr2 = 6'd1; waddr = 6'd0; rsv_addr = 6'd0; wdata = '0;
        #1;
        check("reset rdata1", rdata1[0], 32'h0);
        check("reset busy_count", 32'(bcnt[0]), 32'h0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr1 = 6'(i); raddr2 = 6'(7 - i);
            step();
        end

        write = 1'b1; waddr = 6'd3; wdata = 32'hDEADBEEF;
        step();
        idle(); raddr1 = 6'd3; #2;
        check("r3 stored", rdata1[0], 32'hDEADBEEF);

        write = 1'b1; waddr = 6'd5; wdata = 32'h12345678; raddr2 = 6'd5; #2;
        check("bypass r5", rdata2[0], 32'h12345678);
        raddr2 = 6'h0D; #1;
        check("bypass alias 0x0D", rdata2[0], 32'h12345678);
        step();

        idle(); reserve = 1'b1; rsv_addr = 6'd2;
        step();
        idle(); raddr1 = 6'd2; #1;
        check("busy r2", 32'(busy1[0]), 32'h1);
        check("count after reserve", 32'(bcnt[0]), 32'h1);
        write = 1'b1; waddr = 6'd2; wdata = 32'h000000AA; #1;
        check("busy r2 forwarded", 32'(busy1[0]), 32'h0);
        step();
        idle(); #1;
        check("count after clear", 32'(bcnt[0]), 32'h0);

        write = 1'b1; waddr = 6'd4; wdata = 32'h00000044; reserve = 1'b1; rsv_addr = 6'd4;
        step();
        write = 1'b0; reserve = 1'b1; rsv_addr = 6'd4; raddr1 = 6'd4; #1;
        check("r4 data", rdata1[0], 32'h00000044);
        check("r4 busy", 32'(busy1[0]), 32'h1);
        check("count r4", 32'(bcnt[0]), 32'h1);
        step();
        idle(); #1;
        check("count re-reserve", 32'(bcnt[0]), 32'h1);
        write = 1'b1; waddr = 6'd4; wdata = 32'h00000045;
        step();

        write = 1'b1; waddr = 6'd0; wdata = 32'hFFFFFFFF; reserve = 1'b1; rsv_addr = 6'd0;
        raddr1 = 6'd0; raddr2 = 6'd8; #1;
        check("zero r0 bypass", rdata1[1], 32'h0);
        check("plain r0 bypass", rdata1[0], 32'hFFFFFFFF);
        step();
        idle(); #1;
        check("zero r0 stored", rdata1[1], 32'h0);
        check("zero r0 busy", 32'(busy1[1]), 32'h0);
        check("zero count", 32'(bcnt[1]), 32'h0);
        check("plain count", 32'(bcnt[0]), 32'h1);

        reserve = 1'b1; rsv_addr = 6'd1; step();
        rsv_addr = 6'd6; step();
        idle(); write = 1'b1; waddr = 6'd6; wdata = 32'h7; step();
        idle(); raddr1 = 6'd6; raddr2 = 6'd1; #1;
        check("r6 before reset", rdata1[0], 32'h7);
        write = 1'b1; waddr = 6'd6; wdata = 32'h99; reserve = 1'b1; rsv_addr = 6'd3;
        rst = 1'b1; #1;
        check("async rdata1", rdata1[0], 32'h0);
        check("async busy2", 32'(busy2[0]), 32'h0);
        check("async count", 32'(bcnt[0]), 32'h0);
        step();
        check("write during reset", rdata1[0], 32'h0);
        rst = 1'b0; idle(); raddr2 = 6'd3;
        step();
        check("r6 after reset", rdata1[0], 32'h0);
        check("r3 busy after reset", 32'(busy2[0]), 32'h0);

        for (int i = 0; i < 40; i++) begin
            write = 1'($urandom_range(0, 1)); waddr = 6'($urandom_range(0, 63));
            wdata = $urandom; reserve = 1'($urandom_range(0, 1));
            rsv_addr = 6'($urandom_range(0, 63));
            raddr1 = (i % 3 == 0) ? waddr : 6'($urandom_range(0, 63));
            raddr2 = 6'($urandom_range(0, 63));
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the 8×32 processor register file: DEPTH registers of WIDTH bits, two combinational read ports, one clocked write port, write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard for the issue stage. Sits between decode/issue (read ports, reservations) and writeback (write port); the hazard logic stalls on the busy outputs.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 8, number of registers; power of two, 2..64
- ADDR_W, 6, address port width; ≥ log2(DEPTH)
- ZERO_R0, 0, 1 = register 0 always reads 0, ignores writes and reservations
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits immediately
- raddr1, raddr2  in  ADDR_W  read addresses
- rdata1, rdata2  out  WIDTH  read data (combinational)
- busy1, busy2  out  1  addressed register has a pending producer
- write  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- reserve  in  1  mark a register busy (instruction issued)
- rsv_addr  in  ADDR_W  register to reserve
- busy_count  out  log2(DEPTH)+1  number of busy registers

## Operation
- Index = address mod DEPTH (low log2(DEPTH) bits); upper bits ignored on every address port.
- Write: if write=1, on rising edge reg[waddr] ← wdata; busy[waddr] ← 0.
- Reserve: if reserve=1, on rising edge busy[rsv_addr] ← 1.
- Same edge, same index for write and reserve: data written AND busy stays 1 (new producer wins).
- Read: rdata_n = reg[raddr_n]; bypass: if write=1 and index(waddr)=index(raddr_n) and reset=0, rdata_n = wdata.
- busy_n = busy[raddr_n] & ~(write & index match) — value being written this cycle is forwarded, so not busy.
- ZERO_R0=1: index 0 reads 0, busy 0; writes/reservations to index 0 have no effect (no bypass either).
- busy_count = population count of busy bits after the edge; registered, updated each edge by +1 (new reservation of non-busy reg), −1 (clear of busy reg without same-index reserve), or 0; never exceeds DEPTH nor underflows.
- Write to a non-busy register is legal (clears nothing, stores data).
- Reserve of an already-busy register: no change, no count increment.

## Timing
- Reset values: every register 0, every busy bit 0, busy_count 0, therefore rdata1/2 = 0, busy1/2 = 0 while reset is high.
- reset assertion clears state without waiting for clock; write/reserve during reset ignored; first effective edge is the first rising edge with reset=0.
- Read latency 0 (combinational from address and state); write visible via bypass in the same cycle, via storage from the next cycle.
- Reserve visible on busy_n the cycle after the edge.
- No handshakes; all inputs sampled every rising edge.

## Structure
- Shared package rf_pkg: clog2 function, default WIDTH/DEPTH constants, index-extraction function used by both modules.
- Sub-module reg_scoreboard: busy bit vector, reserve/clear priority, busy_count counter, busy lookups with bypass masking.
- Data array, read muxes and bypass stay in register_file_sb; generate-based, no per-register instances.

## Test plan
- Reset then read all indices -> rdata=0, busy=0, busy_count=0; write 0xDEADBEEF to r3, next cycle raddr1=3 -> 0xDEADBEEF.
- write=1 waddr=5 wdata=0x12345678, raddr2=5 same cycle -> rdata2=0x12345678 before the edge (bypass); raddr2=0x0D (DEPTH=8) -> same data (aliasing).
- reserve r2 -> busy1=1 at raddr1=2, busy_count=1; write r2 next cycle -> busy1=0 that cycle (forwarded), busy_count=0 after edge.
- Same edge write r4 and reserve r4 -> reg[4] holds wdata, busy[4]=1, busy_count +1; reserve r4 again -> count unchanged.
- ZERO_R0=1: write 0xFFFFFFFF to r0 and reserve r0 -> rdata=0, busy=0, busy_count=0, including bypass cycle.
- Reserve r1,r6, write r6=7, assert reset asynchronously between edges -> all rdata, busy, busy_count 0 immediately; writes during reset ignored.
